// File: rtl/rv_ifetch_buf.sv
// Instruction prefetch buffer: fetches sequentially ahead over req/gnt/rvalid and hands tagged words to the core.
// Optional FETCH_PERF_EN adds saturating stall/drop counters (perf_stall_o, perf_drop_o).
module rv_ifetch_buf #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_addr_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_ready_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef FETCH_PERF_EN
   ,output logic [31:0]       perf_stall_o,
    output logic [31:0]       perf_drop_o
`endif
);

    localparam int                PW        = $clog2(DEPTH);
    localparam int                CW        = PW + 1;
    localparam logic [CW:0]       DEPTH_SUM = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]     DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]     C_ONE     = CW'(1);
    localparam logic [PW-1:0]     P_ONE     = PW'(1);
    localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(DATA_W / 8);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     outstanding_q;
    logic [CW-1:0]     drop_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] resp_pc_q;

    logic [CW:0]       credit_used;
    logic              grant;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    // Credit covers both buffered and in-flight words, so every response has a slot.
    assign credit_used  = {1'b0, count_q} + {1'b0, outstanding_q};
    assign mem_req_o    = !rst && !redirect_i && (credit_used < DEPTH_SUM);
    assign mem_addr_o   = rst ? RESET_PC : fetch_pc_q;
    assign grant        = mem_req_o && mem_gnt_i;

    assign fifo_empty   = (count_q == '0);
    assign inst_valid_o = !rst && !fifo_empty && !redirect_i;
    assign inst_o       = (rst || fifo_empty) ? '0 : data_q[rd_ptr_q];
    assign inst_addr_o  = (rst || fifo_empty) ? '0 : addr_q[rd_ptr_q];

    assign pop          = inst_valid_o && inst_ready_i;
    assign push         = !rst && mem_rvalid_i && !redirect_i && (drop_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
        end else if (redirect_i) begin
            // Everything still in flight belongs to the old stream; no grant can happen this cycle.
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= redirect_addr_i;
            resp_pc_q  <= redirect_addr_i;
            if (mem_rvalid_i) begin
                outstanding_q <= outstanding_q - C_ONE;
                drop_q        <= outstanding_q - C_ONE;
            end else begin
                drop_q        <= outstanding_q;
            end
        end else begin
            if (grant) begin
                fetch_pc_q <= fetch_pc_q + PC_INC;
            end

            case ({grant, mem_rvalid_i})
                2'b10:   outstanding_q <= outstanding_q + C_ONE;
                2'b01:   outstanding_q <= outstanding_q - C_ONE;
                default: outstanding_q <= outstanding_q;
            endcase

            if (mem_rvalid_i && (drop_q != '0)) begin
                drop_q <= drop_q - C_ONE;
            end

            if (push) begin
                wr_ptr_q  <= wr_ptr_q + P_ONE;
                resp_pc_q <= resp_pc_q + PC_INC;
            end

            if (pop) begin
                rd_ptr_q <= rd_ptr_q + P_ONE;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + C_ONE;
                2'b01:   count_q <= count_q - C_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= mem_rdata_i;
            addr_q[wr_ptr_q] <= resp_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (credit_used <= DEPTH_SUM);
            assert (!(push && (count_q == DEPTH_CNT)));
        end
    end

`ifdef FETCH_PERF_EN
    logic discard;

    assign discard = !rst && mem_rvalid_i && (redirect_i || (drop_q != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_o <= '0;
            perf_drop_o  <= '0;
        end else begin
            if (inst_ready_i && !inst_valid_o && !redirect_i && (perf_stall_o != '1)) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
            if (discard && (perf_drop_o != '1)) begin
                perf_drop_o <= perf_drop_o + 32'd1;
            end
        end
    end
`else
    // Without the counters, discarded responses and stall cycles are not observed.
`endif

endmodule

// File: tb/tb_rv_ifetch_buf.sv
// Bench for rv_ifetch_buf: table-driven streaming/backpressure/grant-stall rows plus redirect sequences.
// A small in-order memory model answers each grant after a programmable latency with addr ^ 32'hA5A5A5A5.
module tb_rv_ifetch_buf;

    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_o;
    logic [31:0] perf_drop_o;
`endif

    always #5 clk = ~clk;

    rv_ifetch_buf #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_i     (redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .inst_ready_i   (inst_ready_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
`ifdef FETCH_PERF_EN
       ,.perf_stall_o   (perf_stall_o),
        .perf_drop_o    (perf_drop_o)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory model: in-order responses, each due lat cycles after its grant.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    lat       = 1;
    int    cyc       = 0;
    int    bench_out = 0;

    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                assert (bench_out > 0) else $error("rvalid with nothing outstanding");
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend[0].addr ^ PAT;
                void'(pend.pop_front());
                bench_out--;
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = '0;
            end
            @(negedge clk);
            if (rst) begin
                pend.delete();
                bench_out = 0;
            end else if (mem_req_o && mem_gnt_i) begin
                pend.push_back('{addr: mem_addr_o, due: cyc + lat});
                bench_out++;
            end
        end
    end

    task automatic drive(input bit r, input bit rd, input bit g, input bit rdr, input logic [31:0] ra);
        @(posedge clk);
        #1;
        rst             = r;
        inst_ready_i    = rd;
        mem_gnt_i       = g;
        redirect_i      = rdr;
        redirect_addr_i = ra;
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst;
        bit          ready;
        bit          gnt;
        bit          chk_zero;
        bit          exp_valid;
        logic [31:0] exp_iaddr;
        bit          exp_req;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit rd, input bit g, input bit cz,
                       input bit v, input logic [31:0] ia, input bit rq, input logic [31:0] ma);
        vecs.push_back('{rst: r, ready: rd, gnt: g, chk_zero: cz, exp_valid: v,
                         exp_iaddr: ia, exp_req: rq, exp_maddr: ma});
    endtask

    initial begin
        rst             = 1'b1;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        inst_ready_i    = 1'b1;
        mem_gnt_i       = 1'b1;

        // Reset, streaming with ready=1, gnt=1, latency 1
        add(1, 1, 1, 1, 0, 32'h0,  0, 32'h0);
        add(1, 1, 1, 1, 0, 32'h0,  0, 32'h0);
        add(0, 1, 1, 1, 0, 32'h0,  1, 32'h0);
        add(0, 1, 1, 1, 0, 32'h0,  1, 32'h4);
        add(0, 1, 1, 0, 1, 32'h0,  1, 32'h8);
        add(0, 1, 1, 0, 1, 32'h4,  1, 32'hC);
        add(0, 1, 1, 0, 1, 32'h8,  1, 32'h10);
        add(0, 1, 1, 0, 1, 32'hC,  1, 32'h14);
        // Five ungranted cycles: address held at 0x18, then stream resumes
        add(0, 1, 0, 0, 1, 32'h10, 1, 32'h18);
        add(0, 1, 0, 0, 1, 32'h14, 1, 32'h18);
        add(0, 1, 0, 0, 0, 32'h0,  1, 32'h18);
        add(0, 1, 0, 0, 0, 32'h0,  1, 32'h18);
        add(0, 1, 0, 0, 0, 32'h0,  1, 32'h18);
        add(0, 1, 1, 0, 0, 32'h0,  1, 32'h18);
        add(0, 1, 1, 0, 0, 32'h0,  1, 32'h1C);
        add(0, 1, 1, 0, 1, 32'h18, 1, 32'h20);
        // Mid-transfer reset
        add(1, 1, 1, 1, 0, 32'h0,  0, 32'h0);
        add(1, 1, 1, 1, 0, 32'h0,  0, 32'h0);
        // ready=0: four grants fill the credit, then drain in order and resume at 0x10
        add(0, 0, 1, 1, 0, 32'h0,  1, 32'h0);
        add(0, 0, 1, 1, 0, 32'h0,  1, 32'h4);
        add(0, 0, 1, 0, 1, 32'h0,  1, 32'h8);
        add(0, 0, 1, 0, 1, 32'h0,  1, 32'hC);
        add(0, 0, 1, 0, 1, 32'h0,  0, 32'h10);
        add(0, 0, 1, 0, 1, 32'h0,  0, 32'h10);
        add(0, 1, 1, 0, 1, 32'h0,  0, 32'h10);
        add(0, 1, 1, 0, 1, 32'h4,  1, 32'h10);
        add(0, 1, 1, 0, 1, 32'h8,  1, 32'h14);
        add(0, 1, 1, 0, 1, 32'hC,  1, 32'h18);
        add(0, 1, 1, 0, 1, 32'h10, 1, 32'h1C);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ready, vecs[i].gnt, 1'b0, 32'h0);
            chk($sformatf("row%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("row%0d_req", i),   {31'b0, mem_req_o},    {31'b0, vecs[i].exp_req});
            chk($sformatf("row%0d_maddr", i), mem_addr_o, vecs[i].exp_maddr);
            if (vecs[i].exp_valid || vecs[i].chk_zero) begin
                chk($sformatf("row%0d_iaddr", i), inst_addr_o, vecs[i].exp_iaddr);
                chk($sformatf("row%0d_inst", i), inst_o,
                    vecs[i].exp_valid ? (vecs[i].exp_iaddr ^ PAT) : 32'h0);
            end
        end

        // Redirect with 0x8 and 0xC in flight (latency 3)
        lat = 3;
        drive(1, 1, 1, 0, 32'h0);
        drive(1, 1, 1, 0, 32'h0);
`ifdef FETCH_PERF_EN
        chk("perf_stall_rst", perf_stall_o, 32'd0);
        chk("perf_drop_rst",  perf_drop_o,  32'd0);
`endif
        drive(0, 1, 1, 0, 32'h0);
        drive(0, 1, 1, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        drive(0, 1, 1, 0, 32'h0);
        chk("rd4_head0", inst_addr_o, 32'h0);
        drive(0, 1, 1, 0, 32'h0);
        chk("rd4_head4", inst_addr_o, 32'h4);
        drive(0, 1, 1, 1, 32'h100);
        chk("rd4_redir_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rd4_redir_req",   {31'b0, mem_req_o},    32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 0, 32'h0);
            chk($sformatf("rd4_gap%0d_valid", k), {31'b0, inst_valid_o}, 32'd0);
            if (k == 0) chk("rd4_refetch_addr", mem_addr_o, 32'h100);
        end
        drive(0, 1, 1, 0, 32'h0);
        chk("rd4_first_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("rd4_first_addr",  inst_addr_o, 32'h100);
        chk("rd4_first_inst",  inst_o, 32'h100 ^ PAT);
`ifdef FETCH_PERF_EN
        chk("perf_drop_rd4",  perf_drop_o,  32'd2);
        chk("perf_stall_rd4", perf_stall_o, 32'd8);
`endif
        drive(0, 1, 1, 0, 32'h0);
        chk("rd4_second_addr", inst_addr_o, 32'h104);
        chk("rd4_second_inst", inst_o, 32'h104 ^ PAT);

        // Redirect coinciding with rvalid, count=2, outstanding=2 (latency 2)
        lat = 2;
        drive(1, 0, 1, 0, 32'h0);
        drive(1, 0, 1, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);
        chk("rd5_pre_head", inst_addr_o, 32'h0);
        chk("rd5_pre_maddr", mem_addr_o, 32'hC);
        drive(0, 1, 1, 1, 32'h200);
        chk("rd5_redir_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rd5_redir_req",   {31'b0, mem_req_o},    32'd0);
        drive(0, 1, 1, 0, 32'h0);
        chk("rd5_empty_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rd5_refetch_req", {31'b0, mem_req_o},    32'd1);
        chk("rd5_refetch_addr", mem_addr_o, 32'h200);
        drive(0, 1, 1, 0, 32'h0);
        chk("rd5_gap1_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rd5_gap1_maddr", mem_addr_o, 32'h204);
        drive(0, 1, 1, 0, 32'h0);
        chk("rd5_gap2_valid", {31'b0, inst_valid_o}, 32'd0);
        drive(0, 1, 1, 0, 32'h0);
        chk("rd5_first_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("rd5_first_addr",  inst_addr_o, 32'h200);
        chk("rd5_first_inst",  inst_o, 32'h200 ^ PAT);
        drive(0, 1, 1, 0, 32'h0);
        chk("rd5_second_addr", inst_addr_o, 32'h204);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
